// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-client single-word sequencer for a 512Kx16 async SRAM
// Define SRAM_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADR_W       = 19,
   parameter int DAT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic             req0_we,
   input  logic [ADR_W-1:0] req0_addr,
   input  logic [DAT_W-1:0] req0_wdata,
   output logic             req0_ack,
   output logic [DAT_W-1:0] req0_rdata,
   input  logic             req1_valid,
   input  logic             req1_we,
   input  logic [ADR_W-1:0] req1_addr,
   input  logic [DAT_W-1:0] req1_wdata,
   output logic             req1_ack,
   output logic [DAT_W-1:0] req1_rdata,
   output logic [ADR_W-1:0] ram_adr,
   output logic [DAT_W-1:0] ram_dat_o,
   input  logic [DAT_W-1:0] ram_dat_i,
   output logic             ram_dat_oe,
   output logic             ram_cs_n,
   output logic             ram_oe_n,
   output logic             ram_we_n
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             gnt_q, gnt_d;
   logic             we_q, we_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DAT_W-1:0] dat_o_q, dat_o_d;
   logic             dat_oe_q, dat_oe_d;
   logic             cs_n_q, cs_n_d;
   logic             oe_n_q, oe_n_d;
   logic             we_n_q, we_n_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic [DAT_W-1:0] rdata0_q, rdata0_d;
   logic [DAT_W-1:0] rdata1_q, rdata1_d;
`ifndef SRAM_FIXED_PRIO_EN
   logic             last_q, last_d;
`endif

   logic             grant_any;
   logic             grant_sel;
   logic             sel_we;
   logic [ADR_W-1:0] sel_addr;
   logic [DAT_W-1:0] sel_wdata;

   always_comb begin
      grant_any = req0_valid | req1_valid;
`ifdef SRAM_FIXED_PRIO_EN
      grant_sel = ~req0_valid;
`else
      // with both requesting, serve the port that was not served last
      if (req0_valid && req1_valid) grant_sel = ~last_q;
      else                          grant_sel = ~req0_valid;
`endif
      sel_we    = grant_sel ? req1_we    : req0_we;
      sel_addr  = grant_sel ? req1_addr  : req0_addr;
      sel_wdata = grant_sel ? req1_wdata : req0_wdata;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_o_d  = dat_o_q;
      dat_oe_d = dat_oe_q;
      cs_n_d   = cs_n_q;
      oe_n_d   = oe_n_q;
      we_n_d   = we_n_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
`ifndef SRAM_FIXED_PRIO_EN
      last_d   = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_any) begin
               state_d  = SETUP;
               gnt_d    = grant_sel;
               we_d     = sel_we;
               adr_d    = sel_addr;
               cs_n_d   = 1'b0;
               dat_oe_d = sel_we;
               if (sel_we) dat_o_d = sel_wdata;
`ifndef SRAM_FIXED_PRIO_EN
               last_d   = grant_sel;
`endif
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
            if (we_q) we_n_d = 1'b0;
            else      oe_n_d = 1'b0;
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = HOLD;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               if (gnt_q) ack1_d = 1'b1;
               else       ack0_d = 1'b1;
               // strobe is still low here, so ram_dat_i is settled
               if (!we_q) begin
                  if (gnt_q) rdata1_d = ram_dat_i;
                  else       rdata0_d = ram_dat_i;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            state_d  = IDLE;
            cs_n_d   = 1'b1;
            dat_oe_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_o_q  <= '0;
         dat_oe_q <= 1'b0;
         cs_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
`ifndef SRAM_FIXED_PRIO_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_o_q  <= dat_o_d;
         dat_oe_q <= dat_oe_d;
         cs_n_q   <= cs_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
`ifndef SRAM_FIXED_PRIO_EN
         last_q   <= last_d;
`endif
      end
   end

   assign req0_ack   = ack0_q;
   assign req1_ack   = ack1_q;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;
   assign ram_adr    = adr_q;
   assign ram_dat_o  = dat_o_q;
   assign ram_dat_oe = dat_oe_q;
   assign ram_cs_n   = cs_n_q;
   assign ram_oe_n   = oe_n_q;
   assign ram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
// Directed vector table, corner sequences, and a randomized run against a reference model.
module tb_sram_arbiter;
   localparam int W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req0_valid, req0_we, req0_ack;
   logic [18:0] req0_addr;
   logic [15:0] req0_wdata, req0_rdata;
   logic        req1_valid, req1_we, req1_ack;
   logic [18:0] req1_addr;
   logic [15:0] req1_wdata, req1_rdata;
   logic [18:0] ram_adr;
   logic [15:0] ram_dat_o, ram_dat_i;
   logic        ram_dat_oe, ram_cs_n, ram_oe_n, ram_we_n;

   logic [15:0] mem [0:1023];
   logic        mem_clr;
   assign ram_dat_i = (!ram_cs_n && !ram_oe_n) ? mem[ram_adr[9:0]] : 16'hDEAD;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      end else if (!ram_cs_n && !ram_we_n) begin
         mem[ram_adr[9:0]] = ram_dat_oe ? ram_dat_o : 16'hBAD0;
      end
   end

   sram_arbiter #(.WAIT_CYCLES(W), .ADR_W(19), .DAT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ack(req0_ack), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ack(req1_ack), .req1_rdata(req1_rdata),
      .ram_adr(ram_adr), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i), .ram_dat_oe(ram_dat_oe),
      .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
   );

   // back-to-back read instances for the WAIT_CYCLES=1 and 15 period checks
   logic        f_valid;
   logic        z1 = 1'b0;
   logic [18:0] za = '0;
   logic [15:0] zd = '0;
   logic [15:0] fixed_rd = 16'h5A5A;
   logic        a1_ack0, a1_ack1, a15_ack0, a15_ack1;
   logic [15:0] a1_rd0, a1_rd1, a15_rd0, a15_rd1, a1_dat_o, a15_dat_o;
   logic [18:0] a1_adr, a15_adr;
   logic        a1_oe, a1_cs, a1_oen, a1_wen, a15_oe, a15_cs, a15_oen, a15_wen;

   sram_arbiter #(.WAIT_CYCLES(1), .ADR_W(19), .DAT_W(16)) u_w1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(f_valid), .req0_we(z1), .req0_addr(za), .req0_wdata(zd),
      .req0_ack(a1_ack0), .req0_rdata(a1_rd0),
      .req1_valid(z1), .req1_we(z1), .req1_addr(za), .req1_wdata(zd),
      .req1_ack(a1_ack1), .req1_rdata(a1_rd1),
      .ram_adr(a1_adr), .ram_dat_o(a1_dat_o), .ram_dat_i(fixed_rd), .ram_dat_oe(a1_oe),
      .ram_cs_n(a1_cs), .ram_oe_n(a1_oen), .ram_we_n(a1_wen)
   );

   sram_arbiter #(.WAIT_CYCLES(15), .ADR_W(19), .DAT_W(16)) u_w15 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(f_valid), .req0_we(z1), .req0_addr(za), .req0_wdata(zd),
      .req0_ack(a15_ack0), .req0_rdata(a15_rd0),
      .req1_valid(z1), .req1_we(z1), .req1_addr(za), .req1_wdata(zd),
      .req1_ack(a15_ack1), .req1_rdata(a15_rd1),
      .ram_adr(a15_adr), .ram_dat_o(a15_dat_o), .ram_dat_i(fixed_rd), .ram_dat_oe(a15_oe),
      .ram_cs_n(a15_cs), .ram_oe_n(a15_oen), .ram_we_n(a15_wen)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int p, input logic v, input logic we,
                          input logic [18:0] a, input logic [15:0] d);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   function automatic logic get_ack(input int p);
      return (p == 0) ? req0_ack : req1_ack;
   endfunction

   function automatic logic [15:0] get_rdata(input int p);
      return (p == 0) ? req0_rdata : req1_rdata;
   endfunction

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; mem_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // single isolated access; counts strobe cycles from the IDLE cycle that samples valid
   task automatic do_access(input int p, input logic we, input logic [18:0] a, input logic [15:0] d,
                            output int lat, output int we_lo, output int oe_lo, output int doe,
                            output logic [15:0] rd);
      lat = -1; we_lo = 0; oe_lo = 0; doe = 0; rd = 16'h0;
      @(posedge clk); #1;
      set_req(p, 1'b1, we, a, d);
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ram_we_n === 1'b0) we_lo++;
         if (ram_oe_n === 1'b0) oe_lo++;
         if (ram_dat_oe === 1'b1) doe++;
         if (get_ack(p) === 1'b1) begin
            lat = n;
            rd = get_rdata(p);
         end
         @(posedge clk); #1;
         if (lat >= 0) break;
      end
      set_req(p, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("ack_single_pulse", {31'd0, get_ack(p)}, 32'd0);
   endtask

   typedef struct {
      int          port;
      logic        we;
      logic [18:0] addr;
      logic [15:0] wdata;
      int          exp_lat;
      int          exp_we_lo;
      int          exp_oe_lo;
      int          exp_doe;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t        vecs [7];
   logic [15:0] ref_mem [0:15];
   logic [1:0]  vhist [0:63];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int lat, we_lo, oe_lo, doe, bad, n, got;
      logic [15:0] rd;
      int order [10];

      vecs[0] = '{0, 1'b1, 19'h00010, 16'hBEEF, 4, 2, 0, 4, 16'h0000};
      vecs[1] = '{1, 1'b0, 19'h00010, 16'h0000, 4, 0, 2, 0, 16'hBEEF};
      vecs[2] = '{1, 1'b1, 19'h00003, 16'h1234, 4, 2, 0, 4, 16'h0000};
      vecs[3] = '{0, 1'b0, 19'h00003, 16'h0000, 4, 0, 2, 0, 16'h1234};
      vecs[4] = '{0, 1'b1, 19'h003FF, 16'hFFFF, 4, 2, 0, 4, 16'h0000};
      vecs[5] = '{1, 1'b0, 19'h003FF, 16'h0000, 4, 0, 2, 0, 16'hFFFF};
      vecs[6] = '{0, 1'b0, 19'h00010, 16'h0000, 4, 0, 2, 0, 16'hBEEF};

      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      f_valid = 1'b0;
      mem_clr = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", {31'd0, ram_cs_n}, 32'd1);
      chk("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
      chk("rst_we_n", {31'd0, ram_we_n}, 32'd1);
      chk("rst_dat_oe", {31'd0, ram_dat_oe}, 32'd0);
      chk("rst_adr", {13'd0, ram_adr}, 32'd0);
      chk("rst_dat_o", {16'd0, ram_dat_o}, 32'd0);
      chk("rst_acks", {30'd0, req1_ack, req0_ack}, 32'd0);
      chk("rst_rdata", {req1_rdata, req0_rdata}, 32'd0);
      mem_clr = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ram_cs_n !== 1'b1 || ram_oe_n !== 1'b1 || ram_we_n !== 1'b1 ||
             ram_dat_oe !== 1'b0 || req0_ack !== 1'b0 || req1_ack !== 1'b0) bad++;
      end
      chk("idle_quiet_cycles_bad", bad, 0);

      for (int i = 0; i < 7; i++) begin
         do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, we_lo, oe_lo, doe, rd);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_we_low", i), we_lo, vecs[i].exp_we_lo);
         chk($sformatf("vec%0d_oe_low", i), oe_lo, vecs[i].exp_oe_lo);
         chk($sformatf("vec%0d_dat_oe", i), doe, vecs[i].exp_doe);
         if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      end
      chk("sram_holds_beef", {16'd0, mem[16]}, 32'h0000BEEF);

      // both ports requesting continuously from reset
      pulse_reset();
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 19'h00010, '0);
      set_req(1, 1'b1, 1'b0, 19'h00003, '0);
      n = 0;
      for (int c = 0; c < 200 && n < 10; c++) begin
         @(negedge clk);
         if (req0_ack === 1'b1 && n < 10) begin order[n] = 0; n++; end
         if (req1_ack === 1'b1 && n < 10) begin order[n] = 1; n++; end
         @(posedge clk); #1;
      end
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      chk("rr_grant_count", n, 10);
      for (int i = 0; i < n; i++) begin
`ifdef SRAM_FIXED_PRIO_EN
         chk($sformatf("prio_grant%0d", i), order[i], 0);
`else
         chk($sformatf("rr_grant%0d", i), order[i], i % 2);
`endif
      end
      repeat (8) @(posedge clk);

      // reset while a write strobe is active
      #1 set_req(0, 1'b1, 1'b1, 19'h00020, 16'h1111);
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk);
         if (ram_we_n === 1'b0) got = 1;
      end
      chk("abort_reached_access", got, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_we_n", {31'd0, ram_we_n}, 32'd1);
      chk("abort_cs_n", {31'd0, ram_cs_n}, 32'd1);
      chk("abort_dat_oe", {31'd0, ram_dat_oe}, 32'd0);
      set_req(0, 1'b0, 1'b0, '0, '0);
      bad = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (req0_ack !== 1'b0) bad++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (req0_ack !== 1'b0 || ram_cs_n !== 1'b1) bad++;
      end
      chk("abort_no_ack", bad, 0);
      do_access(0, 1'b0, 19'h00010, '0, lat, we_lo, oe_lo, doe, rd);
      chk("after_abort_latency", lat, 4);
      chk("after_abort_rdata", {16'd0, rd}, 32'h0000BEEF);

      // randomized traffic against the reference model
      begin : rand_phase
         logic        pend [2];
         logic        done [2];
         int          age [2];
         logic        rq_we [2];
         logic [18:0] rq_addr [2];
         logic [15:0] rq_wdata [2];
         int          cyc, acks, p, s, exp_p;
         logic [1:0]  v;
         logic        model_last;

         @(posedge clk); #1;
         rst_n = 1'b0; mem_clr = 1'b1;
         @(posedge clk); #1;
         mem_clr = 1'b0;
         @(posedge clk); #1 rst_n = 1'b1;
         for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
         for (int i = 0; i < 64; i++) vhist[i] = 2'b00;
         for (int q = 0; q < 2; q++) begin
            pend[q] = 1'b0; done[q] = 1'b0; age[q] = 0;
            rq_we[q] = 1'b0; rq_addr[q] = '0; rq_wdata[q] = '0;
         end
         model_last = 1'b1;
         cyc = 100;
         acks = 0;
         for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            cyc++;
            for (int q = 0; q < 2; q++) begin
               if (done[q]) begin
                  pend[q] = 1'b0; done[q] = 1'b0;
               end else if (!pend[q] && $urandom_range(0, 2) == 0) begin
                  pend[q]     = 1'b1;
                  age[q]      = 0;
                  rq_we[q]    = 1'($urandom_range(0, 1));
                  rq_addr[q]  = 19'($urandom_range(0, 15));
                  rq_wdata[q] = 16'($urandom);
               end
               set_req(q, pend[q], rq_we[q], rq_addr[q], rq_wdata[q]);
            end
            vhist[cyc % 64] = {pend[1], pend[0]};
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
               if (pend[q] && !done[q]) age[q]++;
`ifdef SRAM_FIXED_PRIO_EN
               if (q == 0 && age[q] > 30) begin
`else
               if (age[q] > 30) begin
`endif
                  chk($sformatf("rand_timeout_port%0d", q), 32'd1, 32'd0);
                  done[q] = 1'b1;
                  age[q]  = 0;
               end
            end
            if (req0_ack === 1'b1 && req1_ack === 1'b1)
               chk("rand_dual_ack", 32'd1, 32'd0);
            else if (req0_ack === 1'b1 || req1_ack === 1'b1) begin
               p = (req1_ack === 1'b1) ? 1 : 0;
               s = cyc - (W + 2);
               v = vhist[s % 64];
               if (v == 2'b11) begin
`ifdef SRAM_FIXED_PRIO_EN
                  exp_p = 0;
`else
                  exp_p = model_last ? 0 : 1;
`endif
               end else if (v == 2'b01) exp_p = 0;
               else if (v == 2'b10) exp_p = 1;
               else exp_p = 2;
               chk($sformatf("rand_grant_c%0d", cyc), p, exp_p);
               if (pend[p]) begin
                  if (rq_we[p]) ref_mem[rq_addr[p][3:0]] = rq_wdata[p];
                  else chk($sformatf("rand_rdata_c%0d", cyc), {16'd0, get_rdata(p)},
                           {16'd0, ref_mem[rq_addr[p][3:0]]});
               end
               model_last = p[0];
               done[p] = 1'b1;
               age[p] = 0;
               acks++;
            end
         end
         set_req(0, 1'b0, 1'b0, '0, '0);
         set_req(1, 1'b0, 1'b0, '0, '0);
         chk("rand_progress", {31'd0, acks > 50}, 32'd1);
      end

      // back-to-back reads with WAIT_CYCLES=1 and 15
      begin : period_phase
         int t1 [4];
         int t15 [4];
         int n1, n15;
         pulse_reset();
         f_valid = 1'b1;
         n1 = 0; n15 = 0;
         for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (a1_ack0 === 1'b1 && n1 < 4) begin t1[n1] = c; n1++; end
            if (a15_ack0 === 1'b1 && n15 < 4) begin t15[n15] = c; n15++; end
            if (c == 20) chk("w1_rdata", {16'd0, a1_rd0}, 32'h00005A5A);
         end
         f_valid = 1'b0;
         chk("w1_ack_count", {31'd0, n1 >= 3}, 32'd1);
         chk("w15_ack_count", {31'd0, n15 >= 3}, 32'd1);
         if (n1 >= 3) begin
            chk("w1_period_a", t1[1] - t1[0], 4);
            chk("w1_period_b", t1[2] - t1[1], 4);
         end
         if (n15 >= 3) begin
            chk("w15_period_a", t15[1] - t15[0], 18);
            chk("w15_period_b", t15[2] - t15[1], 18);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
